// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution unit.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
package branch_pkg;

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpBeq  = 3'd1,
    OpBne  = 3'd2,
    OpBlez = 3'd3,
    OpBgtz = 3'd4,
    OpBltz = 3'd5,
    OpBgez = 3'd6,
    OpJump = 3'd7
  } branch_op_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Zero and equality checkers shared with the ALU flag logic.
  function automatic logic is_zero(input logic [31:0] v);
    return v == 32'd0;
  endfunction

  function automatic logic is_equal(input logic [31:0] a, input logic [31:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/branch_flag_stage.sv
// Stage A of branch_resolve: registers the request and derives the
// equal/zero/negative flags from the latched operands.
module branch_flag_stage
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  branch_op_t       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output branch_op_t       a_op,
  output logic [WIDTH-1:0] a_pc,
  output logic [WIDTH-1:0] a_imm,
  output logic             f_eq,
  output logic             f_zero,
  output logic             f_neg
);

  branch_op_t       op_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] imm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OpNone;
      rs_q  <= '0;
      rt_q  <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (load) begin
      op_q  <= op;
      rs_q  <= rs_val;
      rt_q  <= rt_val;
      pc_q  <= pc;
      imm_q <= imm;
    end
  end

  assign f_eq   = is_equal(rs_q, rt_q);
  assign f_zero = is_zero(rs_q);
  assign f_neg  = rs_q[WIDTH-1];

  assign a_op  = op_q;
  assign a_pc  = pc_q;
  assign a_imm = imm_q;

endmodule

// File: rtl/branch_resolve.sv
// Two-stage branch resolution unit with valid/ready handshakes on both sides.
// Define BRANCH_STATS_EN to add saturating branch/taken output-transfer counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  branch_op_t       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [WIDTH-1:0] next_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      taken_count,
  output logic [31:0]      branch_count
`endif
);

  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic             b_can_load, a_advance, in_fire, b_load;

  branch_op_t       a_op;
  logic [WIDTH-1:0] a_pc, a_imm;
  logic             f_eq, f_zero, f_neg;

  logic             taken_d, taken_q;
  logic [WIDTH-1:0] seq_pc, target_pc, next_pc_d, next_pc_q;

  assign b_can_load = !b_valid_q || out_ready;
  assign a_advance  = a_valid_q && b_can_load;
  assign in_ready   = !rst && !flush && (!a_valid_q || b_can_load);
  assign in_fire    = in_valid && in_ready;
  assign b_load     = a_advance && !flush;

  branch_flag_stage #(
    .WIDTH(WIDTH)
  ) u_flag_stage (
    .clk   (clk),
    .rst   (rst),
    .load  (in_fire),
    .op    (op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .pc    (pc),
    .imm   (imm),
    .a_op  (a_op),
    .a_pc  (a_pc),
    .a_imm (a_imm),
    .f_eq  (f_eq),
    .f_zero(f_zero),
    .f_neg (f_neg)
  );

  always_comb begin
    a_valid_d = a_valid_q;
    if (flush) begin
      a_valid_d = 1'b0;
    end else if (in_fire) begin
      a_valid_d = 1'b1;
    end else if (a_advance) begin
      a_valid_d = 1'b0;
    end

    b_valid_d = b_valid_q;
    if (flush) begin
      b_valid_d = 1'b0;
    end else if (b_can_load) begin
      b_valid_d = a_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
    end
  end

  // Stage B decision: both addition results wrap modulo 2^WIDTH.
  always_comb begin
    taken_d = 1'b0;
    unique case (a_op)
      OpNone:  taken_d = 1'b0;
      OpBeq:   taken_d = f_eq;
      OpBne:   taken_d = !f_eq;
      OpBlez:  taken_d = f_neg || f_zero;
      OpBgtz:  taken_d = !f_neg && !f_zero;
      OpBltz:  taken_d = f_neg;
      OpBgez:  taken_d = !f_neg;
      OpJump:  taken_d = 1'b1;
      default: taken_d = 1'b0;
    endcase
    seq_pc    = a_pc + WIDTH'(PC_STEP);
    target_pc = seq_pc + (a_imm << 2);
    next_pc_d = taken_d ? target_pc : seq_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q   <= 1'b0;
      next_pc_q <= '0;
    end else if (b_load) begin
      taken_q   <= taken_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign out_valid = b_valid_q;
  assign taken     = taken_q;
  assign next_pc   = next_pc_q;

`ifdef BRANCH_STATS_EN
  branch_op_t  b_op_q;
  logic [31:0] taken_cnt_q, branch_cnt_q;
  logic        out_fire;

  assign out_fire = b_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_op_q       <= OpNone;
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      if (b_load) begin
        b_op_q <= a_op;
      end
      // Counted on transfer so flushes never drop an already-delivered result.
      if (out_fire && (b_op_q != OpNone) && (branch_cnt_q != 32'hFFFF_FFFF)) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (out_fire && taken_q && (taken_cnt_q != 32'hFFFF_FFFF)) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign taken_count  = taken_cnt_q;
  assign branch_count = branch_cnt_q;
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Two-stage pipelined branch resolution unit for the single-issue core. Takes a decoded branch op, both register operands, the PC and the sign-extended immediate, and derives zero/equal/sign flags. It emits the taken decision and next PC over a valid/ready handshake. It consumes the flag functions that the ALU flag checkers produce, and sits between decode/register-read and the fetch PC mux.

## Interface
Parameters:
- `WIDTH`, 32: operand, PC and immediate width. Only 32 is supported.

Ports:
- `clk`  in  1: clock, all state updates on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `flush`  in  1: synchronous pipeline kill.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: unit accepts request this cycle.
- `op`  in  3: branch op, `branch_op_t`.
- `rs_val`  in  32: first operand.
- `rt_val`  in  32: second operand.
- `pc`  in  32: PC of branch instruction.
- `imm`  in  32: sign-extended word offset.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts result.
- `taken`  out  1: branch taken.
- `next_pc`  out  32: resolved next PC.
- `taken_count`  out  32: only with `BRANCH_STATS_EN`.
- `branch_count`  out  32: only with `BRANCH_STATS_EN`.

## Operation
- Op encodings: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6, JUMP=7.
- Stage A latches the inputs and computes three flags:
  - `f_eq` = (rs_val == rt_val)
  - `f_zero` = (rs_val == 0)
  - `f_neg` = rs_val[31]
- Stage B decides `taken` from op and flags:
  - BEQ: f_eq. BNE: !f_eq.
  - BLEZ: f_neg | f_zero. BGTZ: !f_neg & !f_zero.
  - BLTZ: f_neg. BGEZ: !f_neg.
  - JUMP: 1. NONE: 0.
- Target = pc + 4 + (imm << 2), truncated to 32 bits. Wraps modulo 2^32 with no overflow flag.
- `next_pc` = taken ? target : pc + 4. pc + 4 also wraps (0xFFFFFFFC -> 0x00000000).
- Handshakes:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - Once out_valid is high, taken and next_pc hold stable until the transfer.
  - in_valid must not depend on in_ready.
- Stage advance:
  - B loads when B is empty or out_ready=1.
  - A loads when A is empty or A advances into B.
  - in_ready = !flush & (!a_valid | b_can_load). A full pipeline with out_ready=1 sustains one result per cycle.
- Flush:
  - Clears a_valid and b_valid next cycle and drops any concurrent input (in_ready=0).
  - A concurrent output transfer still completes.
  - Stats count only completed output transfers.
- Reset behaviour:
  - On rst: in_ready=0 during reset; a_valid=0, b_valid=0, out_valid=0, taken=0, next_pc=0, counters=0.
  - Reset mid-transfer discards all in-flight entries.
  - rst has priority over flush.

## Timing
- Latency is 2 cycles: input accepted at edge N gives out_valid=1 after edge N+1, transferable at edge N+2 if out_ready.
- Throughput is 1/cycle with out_ready held high.
- out_ready low:
  - B holds. A fills once.
  - in_ready drops the cycle after A is occupied and B is stalled.
  - At most 2 entries are in flight.
- No combinational path from in_valid or data inputs to out_valid, taken or next_pc. in_ready depends combinationally on out_ready and flush.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `branch_count` increments on every output transfer with op != NONE.
  - `taken_count` increments on every output transfer with taken=1.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are unaffected by flush.
- Undefined: both ports and counter registers are absent. Decision datapath and timing are unchanged.

## Structure
- `branch_pkg` holds `branch_op_t` (3-bit enum above) and the `PC_STEP`=4 constant.
- Sub-module `branch_flag_stage` is stage A: operand registers plus f_eq/f_zero/f_neg. It is built from the existing zero and equal checkers.
- Stage B, the handshake logic and the stats live in the top module.

## Test plan
- BEQ rs=rt=0x12345678, pc=0x1000, imm=3 -> taken=1, next_pc=0x1010, out_valid 2 cycles after accept.
- BNE rs=0xDEADBEEF, rt=0xDEADBEEE, pc=0xFFFFFFFC, imm=0 -> taken=1, next_pc=0x00000000 (wrap).
- BLEZ/BGTZ/BLTZ/BGEZ with rs=0, 0x80000000, 0x7FFFFFFF -> taken per sign/zero table. NONE -> taken=0, next_pc=pc+4.
- Stream 8 requests, out_ready low for cycles 3-6 -> in_ready drops with exactly 2 held. No loss or reorder. Outputs stable while stalled.
- Flush with 2 entries in flight and in_valid=1 -> out_valid=0 next cycle, the concurrent input is dropped, and the next request resolves normally.
- With BRANCH_STATS_EN: 5 BEQ taken, 3 BNE not taken, 2 NONE -> branch_count=8, taken_count=5. rst -> both 0.
